// File: rtl/mips_pkg.sv
// Shared datapath package: divider FSM states and sign helpers.
// Helpers work on a MAX_W-wide value; callers zero-extend and truncate to their width.
package mips_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    FIN  = 3'd4
  } div_state_e;

  // Two's complement negate when en is set; low bits of the result are correct for any width.
  function automatic wide_t cond_neg(input wide_t v, input logic en);
    wide_t res;
    if (en) begin
      res = wide_t'(0) - v;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Magnitude of a signed value whose sign bit is msb; unsigned values pass through.
  function automatic wide_t abs_val(input wide_t v, input logic msb, input logic sgn);
    return cond_neg(v, msb & sgn);
  endfunction

endpackage

// File: rtl/div_unit_param_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
interface div_unit_param_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/div_unit_param_div_step.sv
// One restoring division step on a {remainder, quotient} pair; swappable for a radix-4 step.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rem_next
);

  logic [WIDTH:0] top_s;
  logic [WIDTH:0] diff_s;

  // The bit shifted out of the upper half is kept as bit WIDTH so the trial cannot overflow.
  assign top_s  = rem[2*WIDTH-1:WIDTH-1];
  assign diff_s = top_s - {1'b0, divisor};

  // Commit the difference and set the quotient bit when the trial is non-negative.
  always_comb begin
    rem_next = {rem[2*WIDTH-2:0], 1'b0};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_next = {diff_s[WIDTH-1:0], rem[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = {rem[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit_param.sv
// Iterative restoring DIV/DIVU: quotient to lo, remainder to hi, one quotient bit per cycle.
// Define EARLY_OUT_EN to finish immediately when |divisor| > |dividend|.
import mips_pkg::*;

module div_unit_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  div_unit_param_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sgn_r;
  logic               sign_q_r;
  logic               sign_r_r;
  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   abs_dvs_r;
  logic [2*WIDTH-1:0] rem_r;
  logic [2*WIDTH-1:0] rem_next_s;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   abs_dvd_s;
  logic [WIDTH-1:0]   abs_dvs_s;
  logic               dvs_zero_s;
  logic               early_s;

  assign abs_dvd_s  = WIDTH'(abs_val(wide_t'(dvd_r), dvd_r[WIDTH-1], sgn_r));
  assign abs_dvs_s  = WIDTH'(abs_val(wide_t'(dvs_r), dvs_r[WIDTH-1], sgn_r));
  assign dvs_zero_s = (dvs_r == '0);

`ifdef EARLY_OUT_EN
  assign early_s = (abs_dvs_s > abs_dvd_s);
`else
  assign early_s = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .divisor  (abs_dvs_r),
    .rem_next (rem_next_s)
  );

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      sgn_r     <= 1'b0;
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      abs_dvs_r <= '0;
      rem_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            sgn_r   <= bus.is_signed;
            dvd_r   <= bus.dividend;
            dvs_r   <= bus.divisor;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= PREP;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        PREP: begin
          if (dvs_zero_s) begin
            dbz_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= FIN;
          end else if (early_s) begin
            lo_r    <= '0;
            hi_r    <= dvd_r;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= FIN;
          end else begin
            // Quotient sign is the XOR of operand signs; remainder follows the dividend.
            sign_q_r  <= sgn_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
            sign_r_r  <= sgn_r & dvd_r[WIDTH-1];
            abs_dvs_r <= abs_dvs_s;
            rem_r     <= {{WIDTH{1'b0}}, abs_dvd_s};
            cnt_r     <= '0;
            state_r   <= ITER;
          end
        end
        ITER: begin
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= ITER;
          end
        end
        FIX: begin
          lo_r    <= WIDTH'(cond_neg(wide_t'(rem_r[WIDTH-1:0]), sign_q_r));
          hi_r    <= WIDTH'(cond_neg(wide_t'(rem_r[2*WIDTH-1:WIDTH]), sign_r_r));
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= FIN;
        end
        FIN: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_div_unit_param.sv
// Scoreboard bench for div_unit_param: 32-bit and 8-bit instances against a plain-arithmetic model.
module tb_div_unit_param;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div_unit_param_if #(.WIDTH(W))  bus32 ();
  div_unit_param_if #(.WIDTH(W8)) bus8 ();

  div_unit_param #(.WIDTH(W))  dut32 (.clk(clk), .reset(reset), .bus(bus32));
  div_unit_param #(.WIDTH(W8)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        dbz;
    int          t_done;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_lo[2];
  logic [63:0] last_hi[2];
  logic        last_dbz[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic busy_of(input int p);
    return (p == 0) ? bus32.busy : bus8.busy;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 0) ? bus32.done : bus8.done;
  endfunction

  function automatic logic dbz_of(input int p);
    return (p == 0) ? bus32.div_by_zero : bus8.div_by_zero;
  endfunction

  // Reference: truncating division on sign-extended 64-bit integers, then wrapped to w bits.
  function automatic void ref_div(input int w, input bit sg, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit early);
    longint      sa, sb, sq, sr;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (sg && a[w-1]) sa = sa - longint'(64'd1 << w);
    if (sg && b[w-1]) sb = sb - longint'(64'd1 << w);
    early = ((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb);
    sq = sa / sb;
    sr = sa % sb;
    q = 64'(sq) & mask;
    r = 64'(sr) & mask;
  endfunction

  task automatic drive(input int p, input logic st, input bit sg, input logic [63:0] a, input logic [63:0] b);
    if (p == 0) begin
      bus32.start = st; bus32.is_signed = sg; bus32.dividend = a[W-1:0]; bus32.divisor = b[W-1:0];
    end else begin
      bus8.start = st; bus8.is_signed = sg; bus8.dividend = a[W8-1:0]; bus8.divisor = b[W8-1:0];
    end
  endtask

  // Called at a negedge while the DUT is idle; asserts start for one cycle and records the expectation.
  task automatic issue(input int p, input bit sg, input logic [63:0] a_in, input logic [63:0] b_in);
    int          w;
    logic [63:0] a, b, q, r, mask;
    bit          early;
    exp_t        e;
    w    = (p == 0) ? W : W8;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    chk("dbz_hold", 64'(dbz_of(p)), 64'(last_dbz[p]));
    drive(p, 1'b1, sg, a, b);
    if (b == 64'd0) begin
      e.lo = last_lo[p]; e.hi = last_hi[p]; e.dbz = 1'b1; e.t_done = cyc + 2;
    end else begin
      ref_div(w, sg, a, b, q, r, early);
      e.lo = q; e.hi = r; e.dbz = 1'b0; e.t_done = cyc + w + 3;
`ifdef EARLY_OUT_EN
      if (early) e.t_done = cyc + 2;
`endif
      last_lo[p] = q;
      last_hi[p] = r;
    end
    last_dbz[p] = e.dbz;
    if (p == 0) q32.push_back(e); else q8.push_back(e);
    @(negedge clk);
    drive(p, 1'b0, 1'($urandom), 64'($urandom), 64'($urandom));
    chk("dbz_clear", 64'(dbz_of(p)), 64'd0);
  endtask

  // Busy must stay high until the done cycle, where it drops; bounded wait.
  task automatic wait_done(input int p);
    int k;
    k = 0;
    while (done_of(p) !== 1'b1 && k < 200) begin
      chk("busy_high", 64'(busy_of(p)), 64'd1);
      @(negedge clk);
      k++;
    end
    if (done_of(p) !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done, required done within 200 cycles (dut %0d)", p);
    end else begin
      chk("busy_at_done", 64'(busy_of(p)), 64'd0);
    end
  endtask

  task automatic op(input int p, input bit sg, input logic [63:0] a, input logic [63:0] b);
    issue(p, sg, a, b);
    wait_done(p);
    @(negedge clk);
  endtask

  // Monitor: pop and compare whenever a DUT presents done.
  always @(negedge clk) begin
    exp_t e;
    if (bus32.done === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_done32: got done, required none (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        chk("lo32", 64'(bus32.lo), e.lo);
        chk("hi32", 64'(bus32.hi), e.hi);
        chk("dbz32", 64'(bus32.div_by_zero), 64'(e.dbz));
        chk("latency32", 64'(cyc), 64'(e.t_done));
      end
    end
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_done8: got done, required none (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("lo8", 64'(bus8.lo), e.lo);
        chk("hi8", 64'(bus8.hi), e.hi);
        chk("dbz8", 64'(bus8.div_by_zero), 64'(e.dbz));
        chk("latency8", 64'(cyc), 64'(e.t_done));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 64'(bus32.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus32.done), 64'd0);
    chk({tag, "_dbz"},  64'(bus32.div_by_zero), 64'd0);
    chk({tag, "_hi"},   64'(bus32.hi), 64'd0);
    chk({tag, "_lo"},   64'(bus32.lo), 64'd0);
    chk({tag, "_lo8"},  64'(bus8.lo), 64'd0);
    chk({tag, "_busy8"}, 64'(bus8.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a, b;
    bit          sg;
    for (int i = 0; i < 2; i++) begin
      last_lo[i] = 64'd0; last_hi[i] = 64'd0; last_dbz[i] = 1'b0;
    end
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed signed/unsigned cases, divide by zero and overflow.
    op(0, 1'b1, 64'd7, 64'd2);
    op(0, 1'b1, 64'hFFFF_FFF9, 64'd2);
    op(0, 1'b1, 64'd7, 64'hFFFF_FFFE);
    op(0, 1'b0, 64'hFFFF_FFFF, 64'd2);
    op(0, 1'b1, 64'hFFFF_FFFF, 64'd2);
    op(0, 1'b1, 64'd123, 64'd0);
    op(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    op(0, 1'b0, 64'd5, 64'd9);
    op(0, 1'b1, 64'd0, 64'd5);
    op(0, 1'b0, 64'hFFFF_FFFF, 64'd1);

    // Start pulses while busy must be ignored.
    issue(0, 1'b1, 64'd100, 64'd3);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 1'b0, 64'd999, 64'd4);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    wait_done(0);
    @(negedge clk);

    // Start held high through FIN is taken in the following IDLE cycle.
    issue(0, 1'b0, 64'd1000, 64'd7);
    wait_done(0);
    drive(0, 1'b1, 1'b1, 64'hFFFF_FC18, 64'd7);
    @(negedge clk);
    issue(0, 1'b1, 64'hFFFF_FC18, 64'd7);
    wait_done(0);
    @(negedge clk);

    // Randomized operations on the 32-bit instance.
    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom);
      a  = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 40)) : 64'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1, 2:    b = 64'($urandom_range(1, 15));
        3:       b = 64'hFFFF_FFFF;
        default: b = 64'($urandom);
      endcase
      op(0, sg, a, b);
    end

    // Asynchronous reset during ITER cycle 10 aborts with no done.
    issue(0, 1'b1, 64'd12345, 64'd17);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    q32.delete();
    for (int i = 0; i < 2; i++) begin
      last_lo[i] = 64'd0; last_hi[i] = 64'd0; last_dbz[i] = 1'b0;
    end
    #1 check_reset_values("midop");
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("no_done_after_abort_q", 64'(q32.size()), 64'd0);

    // 8-bit instance.
    op(1, 1'b0, 64'd100, 64'd7);
    op(1, 1'b1, 64'h80, 64'hFF);
    op(1, 1'b1, 64'd100, 64'd0);
    for (int i = 0; i < 20; i++) begin
      a = 64'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 64'd0 : 64'($urandom_range(1, 255));
      op(1, 1'($urandom), a, b);
    end

    repeat (5) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
